// File: rtl/bomb_controller.sv
`default_nettype none
// ============================================================================
// Module      : bomb_controller
// Description : Per-player bomb lifecycle engine. It snaps a placed bomb to
//               the 32x32 tile grid and counts a fuse in video frames. It then
//               issues tile-clear write requests for the blast cross and holds
//               a blast window for a set number of frames.
//               One live bomb per player.
// Ports       : i_clk          system clock
//               i_rst          asynchronous active-high reset
//               i_frame_pulse  one-clock pulse per video frame
//               i_game_active  1 while in play; 0 aborts any bomb
//               i_place_req    bomb key (level); rising edge places a bomb
//               i_userX/Y      player sprite origin, pixels
//               o_bombX/Y      bomb sprite origin; PARK while no bomb
//               o_bomb_active  bomb lit (fuse running)
//               o_blast_active blast window
//               o_wr_req       clear-tile request, held until i_wr_ack
//               o_wr_addr      tile index row*MAP_COLS+col
//               i_wr_ack       one-clock acknowledge from map write arbiter
// Revision    : 1.0  initial release
// ============================================================================
module bomb_controller #(
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int SPRITE_HALF  = 9,
  parameter int BOMB_OFS     = 8,
  parameter int MAP_COLS     = 20,
  parameter int MAP_ROWS     = 15,
  parameter int PARK         = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_pulse,
  input  logic       i_game_active,
  input  logic       i_place_req,
  input  logic [9:0] i_userX,
  input  logic [9:0] i_userY,
  output logic [9:0] o_bombX,
  output logic [9:0] o_bombY,
  output logic       o_bomb_active,
  output logic       o_blast_active,
  output logic       o_wr_req,
  output logic [9:0] o_wr_addr,
  input  logic       i_wr_ack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FUSE  = 2'd1,
    S_CLEAR = 2'd2,
    S_BLAST = 2'd3
  } state_t;

  localparam logic [15:0] c_FUSE     = 16'(FUSE_FRAMES);
  localparam logic [15:0] c_BLAST    = 16'(BLAST_FRAMES);
  localparam logic [9:0]  c_PARK     = 10'(PARK);
  localparam logic [9:0]  c_COLS     = 10'(MAP_COLS);
  localparam logic [5:0]  c_LAST_COL = 6'(MAP_COLS - 1);
  localparam logic [5:0]  c_LAST_ROW = 6'(MAP_ROWS - 1);

  state_t      r_state;
  logic        r_place_q;
  logic [5:0]  r_col;
  logic [5:0]  r_row;
  logic [15:0] r_fuse;
  logic [15:0] r_blast;
  logic [2:0]  r_slot;
  logic [9:0]  r_bombX;
  logic [9:0]  r_bombY;
  logic        r_bomb_active;
  logic        r_blast_active;
  logic        r_wr_req;
  logic [9:0]  r_wr_addr;

  logic        w_rise;
  logic [10:0] w_sumx;
  logic [10:0] w_sumy;
  logic [5:0]  w_colraw;
  logic [5:0]  w_rowraw;
  logic [5:0]  w_col;
  logic [5:0]  w_row;
  logic [9:0]  w_bx;
  logic [9:0]  w_by;
  logic [9:0]  w_centre;
  logic [9:0]  w_slot_addr;
  logic        w_next_found;
  logic [2:0]  w_next_slot;

  assign w_rise = i_place_req & ~r_place_q;

  // Snap the sprite centre to the tile grid. The sum is 11 bits wide, so a
  // position near 1023 does not wrap. The clamp then pins it to the last tile.
  assign w_sumx   = {1'b0, i_userX} + 11'(SPRITE_HALF);
  assign w_sumy   = {1'b0, i_userY} + 11'(SPRITE_HALF);
  assign w_colraw = 6'(w_sumx >> 5);
  assign w_rowraw = 6'(w_sumy >> 5);
  assign w_col    = (w_colraw > c_LAST_COL) ? c_LAST_COL : w_colraw;
  assign w_row    = (w_rowraw > c_LAST_ROW) ? c_LAST_ROW : w_rowraw;
  assign w_bx     = (10'(w_col) << 5) + 10'(BOMB_OFS);
  assign w_by     = (10'(w_row) << 5) + 10'(BOMB_OFS);

  assign w_centre = 10'(r_row) * c_COLS + 10'(r_col);

  // Slot order: 0 centre, 1 up, 2 down, 3 left, 4 right.
  function automatic logic slot_valid(input logic [2:0] s,
                                      input logic [5:0] col,
                                      input logic [5:0] row);
    case (s)
      3'd0:    slot_valid = 1'b1;
      3'd1:    slot_valid = (row != 6'd0);
      3'd2:    slot_valid = (row != c_LAST_ROW);
      3'd3:    slot_valid = (col != 6'd0);
      3'd4:    slot_valid = (col != c_LAST_COL);
      default: slot_valid = 1'b0;
    endcase
  endfunction

  always_comb begin
    w_slot_addr = w_centre;
    case (r_slot)
      3'd1:    w_slot_addr = w_centre - c_COLS;
      3'd2:    w_slot_addr = w_centre + c_COLS;
      3'd3:    w_slot_addr = w_centre - 10'd1;
      3'd4:    w_slot_addr = w_centre + 10'd1;
      default: w_slot_addr = w_centre;
    endcase
  end

  // Find the lowest-numbered valid slot after the current one. The loop
  // runs downward, so the last match written is the nearest one.
  always_comb begin
    w_next_found = 1'b0;
    w_next_slot  = 3'd0;
    for (int k = 4; k >= 1; k--) begin
      if ((3'(k) > r_slot) && slot_valid(3'(k), r_col, r_row)) begin
        w_next_found = 1'b1;
        w_next_slot  = 3'(k);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_place_q      <= 1'b0;
      r_col          <= 6'd0;
      r_row          <= 6'd0;
      r_fuse         <= 16'd0;
      r_blast        <= 16'd0;
      r_slot         <= 3'd0;
      r_bombX        <= c_PARK;
      r_bombY        <= c_PARK;
      r_bomb_active  <= 1'b0;
      r_blast_active <= 1'b0;
      r_wr_req       <= 1'b0;
      r_wr_addr      <= 10'd0;
    end else begin
      r_place_q <= i_place_req;
      if ((r_state != S_IDLE) && !i_game_active) begin
        // Abort takes priority over everything, including a same-cycle ack.
        r_state        <= S_IDLE;
        r_fuse         <= 16'd0;
        r_blast        <= 16'd0;
        r_slot         <= 3'd0;
        r_bombX        <= c_PARK;
        r_bombY        <= c_PARK;
        r_bomb_active  <= 1'b0;
        r_blast_active <= 1'b0;
        r_wr_req       <= 1'b0;
        r_wr_addr      <= 10'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rise && i_game_active) begin
              r_col         <= w_col;
              r_row         <= w_row;
              r_bombX       <= w_bx;
              r_bombY       <= w_by;
              r_bomb_active <= 1'b1;
              r_fuse        <= c_FUSE;
              r_state       <= S_FUSE;
            end
          end
          S_FUSE: begin
            if (i_frame_pulse) begin
              if (r_fuse == 16'd1) begin
                // The centre tile is always on the map. Its request goes
                // out on the same edge that enters CLEAR.
                r_state       <= S_CLEAR;
                r_fuse        <= 16'd0;
                r_bomb_active <= 1'b0;
                r_bombX       <= c_PARK;
                r_bombY       <= c_PARK;
                r_slot        <= 3'd0;
                r_wr_req      <= 1'b1;
                r_wr_addr     <= w_centre;
              end else begin
                r_fuse <= r_fuse - 16'd1;
              end
            end
          end
          S_CLEAR: begin
            if (r_wr_req) begin
              if (i_wr_ack) begin
                r_wr_req <= 1'b0;
                if (w_next_found) begin
                  r_slot <= w_next_slot;
                end else begin
                  r_state        <= S_BLAST;
                  r_blast_active <= 1'b1;
                  r_blast        <= c_BLAST;
                end
              end
            end else begin
              // wr_req has been low for one cycle; issue the pending slot.
              r_wr_req  <= 1'b1;
              r_wr_addr <= w_slot_addr;
            end
          end
          S_BLAST: begin
            if (i_frame_pulse) begin
              if (r_blast == 16'd1) begin
                r_state        <= S_IDLE;
                r_blast        <= 16'd0;
                r_blast_active <= 1'b0;
              end else begin
                r_blast <= r_blast - 16'd1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_bombX        = r_bombX;
  assign o_bombY        = r_bombY;
  assign o_bomb_active  = r_bomb_active;
  assign o_blast_active = r_blast_active;
  assign o_wr_req       = r_wr_req;
  assign o_wr_addr      = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_bomb_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bomb_controller
// Description : Self-checking bench for bomb_controller. Expected clear
//               addresses are computed from the player position and pushed
//               to a queue when a bomb is placed. They are popped as the DUT
//               raises each request.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bomb_controller;

  localparam int FUSE  = 3;
  localparam int BLAST = 2;
  localparam int PARK  = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_pulse = 1'b0;
  logic       game_active = 1'b1;
  logic       place_req = 1'b0;
  logic [9:0] userX = 10'd0;
  logic [9:0] userY = 10'd0;
  logic [9:0] bombX;
  logic [9:0] bombY;
  logic       bomb_active;
  logic       blast_active;
  logic       wr_req;
  logic [9:0] wr_addr;
  logic       wr_ack = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int exp_bx, exp_by;

  bomb_controller #(
    .FUSE_FRAMES(FUSE), .BLAST_FRAMES(BLAST), .SPRITE_HALF(9), .BOMB_OFS(8),
    .MAP_COLS(20), .MAP_ROWS(15), .PARK(PARK)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_pulse(frame_pulse),
    .i_game_active(game_active), .i_place_req(place_req),
    .i_userX(userX), .i_userY(userY), .o_bombX(bombX), .o_bombY(bombY),
    .o_bomb_active(bomb_active), .o_blast_active(blast_active),
    .o_wr_req(wr_req), .o_wr_addr(wr_addr), .i_wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: compute the tile from the position and queue the cross.
  task automatic model_place(input int ux, input int uy);
    int col, row, c;
    col = (ux + 9) / 32; if (col > 19) col = 19;
    row = (uy + 9) / 32; if (row > 14) row = 14;
    exp_bx = col * 32 + 8;
    exp_by = row * 32 + 8;
    c = row * 20 + col;
    exp_q.push_back(c);
    if (row != 0)  exp_q.push_back(c - 20);
    if (row != 14) exp_q.push_back(c + 20);
    if (col != 0)  exp_q.push_back(c - 1);
    if (col != 19) exp_q.push_back(c + 1);
  endtask

  task automatic place(input int ux, input int uy, input string tag);
    userX = 10'(ux); userY = 10'(uy);
    model_place(ux, uy);
    place_req = 1'b1;
    frame_pulse = 1'b1;          // pulse in the placement cycle must not count
    tick();
    frame_pulse = 1'b0;
    check({tag, "_bomb_active"}, int'(bomb_active), 1);
    check({tag, "_bombX"}, int'(bombX), exp_bx);
    check({tag, "_bombY"}, int'(bombY), exp_by);
  endtask

  task automatic pulse();
    frame_pulse = 1'b1; tick(); frame_pulse = 1'b0; tick();
  endtask

  task automatic run_fuse(input string tag);
    for (int i = 0; i < FUSE; i++) begin
      check({tag, "_lit_before_pulse"}, int'(bomb_active), 1);
      pulse();
    end
    check({tag, "_fuse_done"}, int'(bomb_active), 0);
    check({tag, "_park_x"}, int'(bombX), PARK);
  endtask

  // Serve every queued request; stall_first holds off the first ack.
  task automatic run_clear(input string tag, input int stall_first);
    int gap, first, stable;
    first = 1;
    while (exp_q.size() > 0) begin
      gap = 0;
      while (!wr_req && gap < 20) begin tick(); gap++; end
      if (!wr_req) begin
        check({tag, "_req_timeout"}, 0, 1);
        exp_q.delete();
        return;
      end
      check({tag, "_gap"}, gap, first ? 0 : 1);
      check({tag, "_addr"}, int'(wr_addr), exp_q.pop_front());
      if (first && stall_first > 0) begin
        stable = 1;
        for (int s = 0; s < stall_first; s++) begin
          frame_pulse = (s == 3);     // ignored while clearing
          tick();
          if (!wr_req || wr_addr != 10'd43) stable = 0;
        end
        frame_pulse = 1'b0;
        check({tag, "_stall_stable"}, stable, 1);
      end
      first = 0;
      wr_ack = 1'b1; tick(); wr_ack = 1'b0;
      check({tag, "_req_drop"}, int'(wr_req), 0);
    end
    check({tag, "_blast_on"}, int'(blast_active), 1);
  endtask

  task automatic run_blast(input string tag);
    for (int i = 0; i < BLAST; i++) begin
      check({tag, "_blast_hold"}, int'(blast_active), 1);
      check({tag, "_no_extra_req"}, int'(wr_req), 0);
      pulse();
    end
    check({tag, "_blast_off"}, int'(blast_active), 0);
  endtask

  initial begin
    // 1: reset values
    #12;
    check("rst_bombX", int'(bombX), PARK);
    check("rst_bombY", int'(bombY), PARK);
    check("rst_bomb_active", int'(bomb_active), 0);
    check("rst_blast_active", int'(blast_active), 0);
    check("rst_wr_req", int'(wr_req), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // 2+4: normal placement, held key, stalled first ack
    place(100, 70, "norm");
    run_fuse("norm");
    run_clear("norm", 10);
    run_blast("norm");
    repeat (3) tick();
    check("held_key_no_replace", int'(bomb_active), 0);
    place_req = 1'b0; tick();

    // 3: top-left corner
    place(0, 0, "corner");
    place_req = 1'b0; tick();
    place_req = 1'b1; tick();          // rise during FUSE is ignored
    check("fuse_rise_ignored_x", int'(bombX), exp_bx);
    place_req = 1'b0;
    run_fuse("corner");
    run_clear("corner", 0);
    place_req = 1'b1; tick(); place_req = 1'b0;   // rise during BLAST ignored
    run_blast("corner");
    tick();
    check("blast_rise_ignored", int'(bomb_active), 0);

    // 3: bottom-right clamp
    place(1023, 1023, "clamp");
    place_req = 1'b0;
    run_fuse("clamp");
    run_clear("clamp", 0);
    run_blast("clamp");

    // 6: abort mid-FUSE
    tick();
    place(200, 200, "abf");
    place_req = 1'b0;
    exp_q.delete();
    pulse();
    game_active = 1'b0; tick();
    check("abort_fuse_active", int'(bomb_active), 0);
    check("abort_fuse_park", int'(bombX), PARK);
    game_active = 1'b1; tick();

    // 6: abort mid-CLEAR with simultaneous ack
    place(200, 200, "abc");
    place_req = 1'b0;
    exp_q.delete();
    run_fuse("abc");
    check("abc_req_pending", int'(wr_req), 1);
    game_active = 1'b0; wr_ack = 1'b1; tick();
    wr_ack = 1'b0; game_active = 1'b1;
    check("abort_clear_req", int'(wr_req), 0);
    repeat (3) tick();
    check("abort_clear_no_more", int'(wr_req), 0);
    check("abort_clear_no_blast", int'(blast_active), 0);

    // 6: async reset mid-BLAST
    place(300, 100, "arst");
    place_req = 1'b0;
    run_fuse("arst");
    run_clear("arst", 0);
    #2 rst = 1'b1;
    #1 check("async_rst_blast", int'(blast_active), 0);
    check("async_rst_park", int'(bombY), PARK);
    @(negedge clk); rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
